// File: rtl/regbank_pkg.sv
// Shared definitions for the general-purpose register bank and its port sequencer.
package regbank_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 16;
    localparam int REG_AW = 4;

    // x0 is hard-wired to zero: reads return 0 and writes are dropped.
    localparam logic [REG_AW-1:0] ZERO_REG = '0;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        HOLD,
        WR
    } seq_state_e;

endpackage

// File: rtl/regbank_port_sequencer_if.sv
// Operand-request, writeback and bank-port signals of the register bank port sequencer.
interface regbank_port_sequencer_if;
    import regbank_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [REG_AW-1:0] req_rs1;
    logic [REG_AW-1:0] req_rs2;

    logic              op_valid;
    logic              op_ready;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;

    logic              wb_valid;
    logic              wb_ready;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;

    logic [REG_AW-1:0] bank_select;
    logic              bank_write;
    logic [XLEN-1:0]   bank_wdata;
    logic [XLEN-1:0]   bank_rdata;

    // master: the sequencer; slave: decode/execute plus the register bank.
    modport master (
        input  req_valid, req_rs1, req_rs2, op_ready, wb_valid, wb_rd, wb_data, bank_rdata,
        output req_ready, op_valid, op_a, op_b, wb_ready, bank_select, bank_write, bank_wdata
    );

    modport slave (
        output req_valid, req_rs1, req_rs2, op_ready, wb_valid, wb_rd, wb_data, bank_rdata,
        input  req_ready, op_valid, op_a, op_b, wb_ready, bank_select, bank_write, bank_wdata
    );

endinterface

// File: rtl/regbank_port_sequencer.sv
// Serialises two-operand reads and single-cycle writebacks onto the single-port register bank.
//
// state | meaning
// IDLE  | ready for a writeback (priority) or an operand read request
// RD_A  | bank_select = rs1, capture op_a (and op_b when rs2 == rs1)
// RD_B  | bank_select = rs2, capture op_b
// HOLD  | op_valid high, operands held until op_ready
// WR    | drive latched rd/data to the bank; write suppressed for x0
module regbank_port_sequencer
    import regbank_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    regbank_port_sequencer_if.master bus
);

    seq_state_e        state_q, state_d;
    logic [REG_AW-1:0] rs1_q, rs1_d;
    logic [REG_AW-1:0] rs2_q, rs2_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   op_a_q, op_a_d;
    logic [XLEN-1:0]   op_b_q, op_b_d;

    logic              req_ready;
    logic              wb_ready;
    logic              op_valid;
    logic [REG_AW-1:0] bank_select;
    logic              bank_write;
    logic [XLEN-1:0]   bank_wdata;
    logic [XLEN-1:0]   rd_value;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            wdata_q <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
        end else begin
            state_q <= state_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            wdata_q <= wdata_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        wdata_d     = wdata_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        req_ready   = 1'b0;
        wb_ready    = 1'b0;
        op_valid    = 1'b0;
        bank_select = ZERO_REG;
        bank_write  = 1'b0;
        bank_wdata  = '0;
        rd_value    = '0;

        case (state_q)
            IDLE: begin
                wb_ready  = 1'b1;
                // Writeback wins so a read issued alongside it sees the new value.
                req_ready = !bus.wb_valid;
                if (bus.wb_valid) begin
                    rd_d    = bus.wb_rd;
                    wdata_d = bus.wb_data;
                    state_d = WR;
                end else if (bus.req_valid) begin
                    rs1_d   = bus.req_rs1;
                    rs2_d   = bus.req_rs2;
                    state_d = RD_A;
                end
            end
            WR: begin
                bank_select = rd_q;
                bank_wdata  = wdata_q;
                bank_write  = (rd_q != ZERO_REG);
                state_d     = IDLE;
            end
            RD_A: begin
                bank_select = rs1_q;
                rd_value    = (rs1_q == ZERO_REG) ? '0 : bus.bank_rdata;
                op_a_d      = rd_value;
                if (rs2_q == rs1_q) begin
                    op_b_d  = rd_value;
                    state_d = HOLD;
                end else begin
                    state_d = RD_B;
                end
            end
            RD_B: begin
                bank_select = rs2_q;
                op_b_d      = (rs2_q == ZERO_REG) ? '0 : bus.bank_rdata;
                state_d     = HOLD;
            end
            HOLD: begin
                op_valid = 1'b1;
                if (bus.op_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Nothing is offered or written to the bank while reset is held.
        if (reset) begin
            req_ready   = 1'b0;
            wb_ready    = 1'b0;
            op_valid    = 1'b0;
            bank_select = ZERO_REG;
            bank_write  = 1'b0;
            bank_wdata  = '0;
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.wb_ready    = wb_ready;
    assign bus.op_valid    = op_valid;
    assign bus.op_a        = op_a_q;
    assign bus.op_b        = op_b_q;
    assign bus.bank_select = bank_select;
    assign bus.bank_write  = bank_write;
    assign bus.bank_wdata  = bank_wdata;

endmodule
